// File: rtl/sdram_responder_pkg.sv
// Shared SDRAM definitions: command encodings, mode-register fields,
// default timings and the init-sequence state type.
package sdram_responder_pkg;

    // {ras, cas, we}, all active low
    localparam logic [2:0] SDRAM_CMD_NOP   = 3'b111;
    localparam logic [2:0] SDRAM_CMD_ACT   = 3'b011;
    localparam logic [2:0] SDRAM_CMD_READ  = 3'b101;
    localparam logic [2:0] SDRAM_CMD_WRITE = 3'b100;
    localparam logic [2:0] SDRAM_CMD_BST   = 3'b110;
    localparam logic [2:0] SDRAM_CMD_PRE   = 3'b010;
    localparam logic [2:0] SDRAM_CMD_AR    = 3'b001;
    localparam logic [2:0] SDRAM_CMD_MRS   = 3'b000;

    // Mode register / address field positions
    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BT_BIT = 3;
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_WB_BIT = 9;
    localparam int ADDR_A10    = 10;

    // Default core timings in cycles
    localparam int SDRAM_T_RCD  = 3;
    localparam int SDRAM_T_RP   = 3;
    localparam int SDRAM_T_RFC  = 7;
    localparam int SDRAM_T_MRD  = 2;
    localparam int SDRAM_T_REFI = 1560;

    // Width of the per-bank and global command-spacing timers
    localparam int TIMER_W = 8;

    // Sticky error flag positions
    localparam int ERR_INIT   = 0;
    localparam int ERR_OPEN   = 1;
    localparam int ERR_CLOSED = 2;
    localparam int ERR_RCD    = 3;
    localparam int ERR_RP     = 4;
    localparam int ERR_BUSY   = 5;
    localparam int ERR_REFI   = 6;
    localparam int ERR_MODE   = 7;

    typedef enum logic [2:0] {
        INIT_WAIT_PRE = 3'd0,
        INIT_WAIT_AR1 = 3'd1,
        INIT_WAIT_AR2 = 3'd2,
        INIT_WAIT_MRS = 3'd3,
        INIT_READY    = 3'd4
    } init_state_t;

    // A mode word is usable only with BL 1/2/4/8, sequential bursts, CL 2 or 3
    function automatic logic mode_ok(input logic [11:0] m);
        return (m[MODE_BL_LSB +: 3] <= 3'd3) && !m[MODE_BT_BIT] &&
               ((m[MODE_CL_LSB +: 3] == 3'd2) || (m[MODE_CL_LSB +: 3] == 3'd3));
    endfunction

endpackage

// File: rtl/sdram_responder_bank.sv
// One SDRAM bank: open flag, open row, tRCD/tRP timers and the
// per-bank protocol checks for ACT and READ/WRITE.
module sdram_responder_bank
    import sdram_responder_pkg::*;
#(
    parameter int ROW_W = 2,
    parameter int T_RCD = SDRAM_T_RCD,
    parameter int T_RP  = SDRAM_T_RP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             act_req,
    input  logic             rw_req,
    input  logic             close,
    input  logic [ROW_W-1:0] act_row,
    output logic             is_open,
    output logic [ROW_W-1:0] row,
    output logic             act_open_err,
    output logic             act_rp_err,
    output logic             rw_closed_err,
    output logic             rw_rcd_err
);

    localparam logic [TIMER_W-1:0] RCD_LOAD = TIMER_W'(T_RCD - 1);
    localparam logic [TIMER_W-1:0] RP_LOAD  = TIMER_W'(T_RP - 1);

    logic [TIMER_W-1:0] rcd_cnt;
    logic [TIMER_W-1:0] rp_cnt;
    logic               act_go;

    // Violation checks for the command presented this cycle; a flagged ACT is dropped
    always_comb begin
        act_open_err  = act_req && is_open;
        act_rp_err    = act_req && (rp_cnt != '0);
        rw_closed_err = rw_req && !is_open;
        rw_rcd_err    = rw_req && is_open && (rcd_cnt != '0);
        act_go        = act_req && !is_open && (rp_cnt == '0);
    end

    // Open/close state and timers; a timer loaded at edge n reads zero at edge n+T
    always_ff @(posedge clk) begin
        if (rst) begin
            is_open <= 1'b0;
            row     <= '0;
            rcd_cnt <= '0;
            rp_cnt  <= '0;
        end else begin
            if (close) begin
                is_open <= 1'b0;
                rp_cnt  <= RP_LOAD;
            end else if (rp_cnt != '0) begin
                rp_cnt <= rp_cnt - 1'b1;
            end
            if (act_go && !close) begin
                is_open <= 1'b1;
                row     <= act_row;
                rcd_cnt <= RCD_LOAD;
            end else if (rcd_cnt != '0) begin
                rcd_cnt <= rcd_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_responder.sv
// Device-side SDR SDRAM model: command decode, init sequencing, mode
// register, timing checks, burst engines and an internal block RAM.
//
// Handshake: there is no valid/ready pair; a command is valid on any edge
// where cke=1, cs_n=0 and {ras,cas,we} is not NOP. It is accepted only if it
// raises no violation; rejected commands set err bits and have no effect.
module sdram_responder
    import sdram_responder_pkg::*;
#(
    parameter int COL_BITS = 8,
    parameter int MEM_AW   = 12,
    parameter int T_RCD    = SDRAM_T_RCD,
    parameter int T_RP     = SDRAM_T_RP,
    parameter int T_RFC    = SDRAM_T_RFC,
    parameter int T_MRD    = SDRAM_T_MRD,
    parameter int T_REFI   = SDRAM_T_REFI
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cke,
    input  logic        cs_n,
    input  logic        ras,
    input  logic        cas,
    input  logic        we,
    input  logic [11:0] address,
    input  logic [1:0]  bank,
    input  logic [15:0] data_in,
    input  logic [1:0]  data_mask,
    output logic [15:0] data_out,
    output logic        data_oe,
    output logic        ready,
    output logic [11:0] mode,
    input  logic        err_clear,
    output logic [7:0]  err,
    output init_state_t dbg_state
);

    localparam int ROW_W  = MEM_AW - COL_BITS - 2;
    localparam int REFI_W = $clog2(T_REFI + 1);
    localparam logic [REFI_W-1:0] REFI_MAX  = REFI_W'(T_REFI);
    localparam logic [REFI_W-1:0] REFI_WARN = REFI_W'(T_REFI - 1);

    // Column advance wrapping inside the BL-aligned block (m = BL-1)
    function automatic logic [COL_BITS-1:0] col_step(input logic [COL_BITS-1:0] c,
                                                     input logic [2:0] m);
        logic [COL_BITS-1:0] mk;
        mk = {{(COL_BITS-3){1'b0}}, m};
        return (c & ~mk) | ((c + 1'b1) & mk);
    endfunction

    init_state_t state, state_next;
    logic [2:0]  cmd;
    logic        cmd_valid, is_act, is_rd, is_wr, is_bst, is_pre, is_ar, is_mrs;
    logic        expected, busy, go, bank_go, in_ready, any_open;
    logic        ar_go, mrs_go, pre_go, rd_go, wr_go, bst_go, sel_bad;
    logic [TIMER_W-1:0] busy_cnt;
    logic [REFI_W-1:0]  refi_cnt;
    logic [7:0]  err_set;

    // Effective burst configuration
    logic        mode_valid, wlen_one;
    logic [3:0]  bl_len;
    logic [2:0]  bl_mask, cl;

    // Bank array signals
    logic [3:0]       act_req, rw_req, close_bank, bank_open;
    logic [3:0]       b_act_open, b_act_rp, b_rw_closed, b_rw_rcd;
    logic [ROW_W-1:0] bank_row [4];

    // Burst engines
    logic [2:0]          rd_wait, rd_mask, wr_mask;
    logic [3:0]          rd_left, wr_left;
    logic [COL_BITS-1:0] rd_col, wr_col;
    logic [1:0]          rd_bank, wr_bank;
    logic [ROW_W-1:0]    rd_row, wr_row;
    logic                rd_ap, wr_ap, rd_kill, wr_kill, rd_fire, wr_fire, mem_we;
    logic [MEM_AW-1:0]   waddr, raddr;

    logic [15:0] mem [0:(1<<MEM_AW)-1];

    assign cmd       = (cke && !cs_n) ? {ras, cas, we} : SDRAM_CMD_NOP;
    assign in_ready  = (state == INIT_READY);
    assign ready     = in_ready;
    assign dbg_state = state;

    // Mode decode: an unusable mode word runs as BL=1, CL=2
    always_comb begin
        mode_valid = mode_ok(mode);
        bl_len     = 4'd1;
        bl_mask    = 3'd0;
        cl         = 3'd2;
        if (mode_valid) begin
            cl = mode[MODE_CL_LSB +: 3];
            case (mode[MODE_BL_LSB +: 3])
                3'd1:    begin bl_len = 4'd2; bl_mask = 3'd1; end
                3'd2:    begin bl_len = 4'd4; bl_mask = 3'd3; end
                3'd3:    begin bl_len = 4'd8; bl_mask = 3'd7; end
                default: begin bl_len = 4'd1; bl_mask = 3'd0; end
            endcase
        end
        wlen_one = mode[MODE_WB_BIT] || (bl_len == 4'd1);
    end

    // Command qualification: decode, init gating, global and per-bank checks
    always_comb begin
        cmd_valid = (cmd != SDRAM_CMD_NOP);
        is_act    = (cmd == SDRAM_CMD_ACT);
        is_rd     = (cmd == SDRAM_CMD_READ);
        is_wr     = (cmd == SDRAM_CMD_WRITE);
        is_bst    = (cmd == SDRAM_CMD_BST);
        is_pre    = (cmd == SDRAM_CMD_PRE);
        is_ar     = (cmd == SDRAM_CMD_AR);
        is_mrs    = (cmd == SDRAM_CMD_MRS);
        case (state)
            INIT_WAIT_PRE:                 expected = is_pre && address[ADDR_A10];
            INIT_WAIT_AR1, INIT_WAIT_AR2:  expected = is_ar;
            INIT_WAIT_MRS:                 expected = is_mrs;
            default:                       expected = 1'b1;
        endcase
        busy     = (busy_cnt != '0);
        go       = cmd_valid && !busy && expected;
        bank_go  = go && in_ready;
        any_open = |bank_open;
        ar_go    = go && is_ar && !any_open;
        mrs_go   = go && is_mrs;
        pre_go   = go && is_pre;
        bst_go   = bank_go && is_bst;
        act_req  = '0;
        rw_req   = '0;
        for (int b = 0; b < 4; b++) begin
            act_req[b] = bank_go && is_act && (bank == 2'(b));
            rw_req[b]  = bank_go && (is_rd || is_wr) && (bank == 2'(b));
        end
        sel_bad = b_rw_closed[bank] || b_rw_rcd[bank];
        rd_go   = bank_go && is_rd && !sel_bad;
        wr_go   = bank_go && is_wr && !sel_bad;

        err_set           = '0;
        err_set[ERR_INIT]   = cmd_valid && !busy && !expected;
        err_set[ERR_OPEN]   = (|b_act_open) || (go && is_ar && any_open);
        err_set[ERR_CLOSED] = |b_rw_closed;
        err_set[ERR_RCD]    = |b_rw_rcd;
        err_set[ERR_RP]     = |b_act_rp;
        err_set[ERR_BUSY]   = cmd_valid && busy;
        err_set[ERR_REFI]   = in_ready && !ar_go && (refi_cnt >= REFI_WARN);
        err_set[ERR_MODE]   = mrs_go && !mode_ok(address);
    end

    // Burst termination, per-edge RAM activity and bank close requests
    always_comb begin
        rd_kill = wr_go || bst_go || (pre_go && (address[ADDR_A10] || (bank == rd_bank)));
        wr_kill = rd_go || bst_go || (pre_go && (address[ADDR_A10] || (bank == wr_bank)));
        rd_fire = !rd_go && !rd_kill && (rd_wait == '0) && (rd_left != '0);
        wr_fire = !wr_go && !wr_kill && (wr_left != '0);
        mem_we  = (wr_go || wr_fire) && !rst;
        waddr   = wr_go ? {bank, bank_row[bank], address[COL_BITS-1:0]}
                        : {wr_bank, wr_row, wr_col};
        raddr   = {rd_bank, rd_row, rd_col};
        close_bank = '0;
        for (int b = 0; b < 4; b++) begin
            close_bank[b] = (pre_go && (address[ADDR_A10] || (bank == 2'(b)))) ||
                            (wr_go && address[ADDR_A10] && wlen_one && (bank == 2'(b))) ||
                            (wr_fire && wr_ap && (wr_left == 4'd1) && (wr_bank == 2'(b))) ||
                            (rd_fire && rd_ap && (rd_left == 4'd1) && (rd_bank == 2'(b)));
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_bank
        sdram_responder_bank #(.ROW_W(ROW_W), .T_RCD(T_RCD), .T_RP(T_RP)) u_bank (
            .clk          (clk),
            .rst          (rst),
            .act_req      (act_req[g]),
            .rw_req       (rw_req[g]),
            .close        (close_bank[g]),
            .act_row      (address[ROW_W-1:0]),
            .is_open      (bank_open[g]),
            .row          (bank_row[g]),
            .act_open_err (b_act_open[g]),
            .act_rp_err   (b_act_rp[g]),
            .rw_closed_err(b_rw_closed[g]),
            .rw_rcd_err   (b_rw_rcd[g])
        );
    end

    // Init FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= INIT_WAIT_PRE;
        else     state <= state_next;
    end

    // Init FSM next state: advance only on the accepted expected command
    always_comb begin
        state_next = state;
        case (state)
            INIT_WAIT_PRE: if (pre_go) state_next = INIT_WAIT_AR1;
            INIT_WAIT_AR1: if (ar_go)  state_next = INIT_WAIT_AR2;
            INIT_WAIT_AR2: if (ar_go)  state_next = INIT_WAIT_MRS;
            INIT_WAIT_MRS: if (mrs_go) state_next = INIT_READY;
            default:       state_next = state;
        endcase
    end

    // Mode register, tRFC/tMRD spacing, refresh interval and sticky errors
    always_ff @(posedge clk) begin
        if (rst) begin
            mode     <= '0;
            busy_cnt <= '0;
            refi_cnt <= '0;
            err      <= '0;
        end else begin
            if (mrs_go) mode <= address;
            if (ar_go)            busy_cnt <= TIMER_W'(T_RFC - 1);
            else if (mrs_go)      busy_cnt <= TIMER_W'(T_MRD - 1);
            else if (busy)        busy_cnt <= busy_cnt - 1'b1;
            if (!in_ready || ar_go)        refi_cnt <= '0;
            else if (refi_cnt != REFI_MAX) refi_cnt <= refi_cnt + 1'b1;
            err <= (err_clear ? 8'h00 : err) | err_set;
        end
    end

    // Read burst engine: CL-1 wait, then one word per edge into data_out
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_wait  <= '0;
            rd_left  <= '0;
            rd_col   <= '0;
            rd_bank  <= '0;
            rd_row   <= '0;
            rd_ap    <= 1'b0;
            rd_mask  <= '0;
            data_out <= '0;
            data_oe  <= 1'b0;
        end else begin
            if (rd_go) begin
                rd_wait <= cl - 3'd1;
                rd_left <= bl_len;
                rd_col  <= address[COL_BITS-1:0];
                rd_bank <= bank;
                rd_row  <= bank_row[bank];
                rd_ap   <= address[ADDR_A10];
                rd_mask <= bl_mask;
            end else if (rd_kill) begin
                rd_wait <= '0;
                rd_left <= '0;
            end else if (rd_wait != '0) begin
                rd_wait <= rd_wait - 3'd1;
            end else if (rd_left != '0) begin
                rd_left <= rd_left - 4'd1;
                rd_col  <= col_step(rd_col, rd_mask);
            end
            data_oe <= rd_fire;
            if (rd_fire) data_out <= mem[raddr];
        end
    end

    // Write burst engine: first word on the command edge, the rest follow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_left <= '0;
            wr_col  <= '0;
            wr_bank <= '0;
            wr_row  <= '0;
            wr_ap   <= 1'b0;
            wr_mask <= '0;
        end else if (wr_go) begin
            wr_left <= wlen_one ? 4'd0 : (bl_len - 4'd1);
            wr_col  <= col_step(address[COL_BITS-1:0], bl_mask);
            wr_bank <= bank;
            wr_row  <= bank_row[bank];
            wr_ap   <= address[ADDR_A10];
            wr_mask <= bl_mask;
        end else if (wr_kill) begin
            wr_left <= '0;
        end else if (wr_left != '0) begin
            wr_left <= wr_left - 4'd1;
            wr_col  <= col_step(wr_col, wr_mask);
        end
    end

    // Backing store write port with per-byte DQM inhibit
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (!data_mask[0]) mem[waddr][7:0]  <= data_in[7:0];
            if (!data_mask[1]) mem[waddr][15:8] <= data_in[15:8];
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, burst write/read, DQM,
// timing violations, refresh interval and reset during a read burst.
module tb_sdram_responder;

    localparam int T_REFI = 400;

    localparam logic [2:0] C_ACT   = 3'b011;
    localparam logic [2:0] C_READ  = 3'b101;
    localparam logic [2:0] C_WRITE = 3'b100;
    localparam logic [2:0] C_PRE   = 3'b010;
    localparam logic [2:0] C_AR    = 3'b001;
    localparam logic [2:0] C_MRS   = 3'b000;

    logic        clk, rst, cke, cs_n, ras, cas, we, err_clear, data_oe, ready;
    logic [11:0] address, mode;
    logic [1:0]  bank, data_mask;
    logic [15:0] data_in, data_out;
    logic [7:0]  err;
    sdram_responder_pkg::init_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    sdram_responder #(.T_REFI(T_REFI)) dut (
        .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras(ras), .cas(cas), .we(we),
        .address(address), .bank(bank), .data_in(data_in), .data_mask(data_mask),
        .data_out(data_out), .data_oe(data_oe), .ready(ready), .mode(mode),
        .err_clear(err_clear), .err(err), .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One command on the next edge, then back to deselect
    task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a);
        cs_n = 1'b0;
        {ras, cas, we} = c;
        bank = b;
        address = a;
        @(posedge clk);
        #1;
        cs_n = 1'b1;
        {ras, cas, we} = 3'b111;
    endtask

    task automatic clear_err();
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cke = 1'b1; cs_n = 1'b1; {ras, cas, we} = 3'b111;
        address = '0; bank = '0; data_in = '0; data_mask = '0; err_clear = 1'b0;
        idle(3);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_oe", 32'(data_oe), 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_mode", 32'(mode), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        // Init: PRE all, AR, AR (tRFC apart), MRS BL=4 CL=3
        drive(C_PRE, 2'd0, 12'h400);
        drive(C_AR, 2'd0, 12'h000);
        idle(6);
        drive(C_AR, 2'd0, 12'h000);
        idle(6);
        check("init_not_ready", 32'(ready), 32'h0);
        drive(C_MRS, 2'd0, 12'h032);
        check("init_ready", 32'(ready), 32'h1);
        check("init_mode", 32'(mode), 32'h032);
        check("init_err", 32'(err), 32'h0);
        idle(1);

        // Burst write 4 words at col 0x10, read back from col 0x12 (wrapped)
        drive(C_ACT, 2'd0, 12'h005);
        idle(2);
        data_in = 16'h1111;
        drive(C_WRITE, 2'd0, 12'h010);
        data_in = 16'h2222; idle(1);
        data_in = 16'h3333; idle(1);
        data_in = 16'h4444; idle(1);
        data_in = 16'h0000;
        drive(C_READ, 2'd0, 12'h012);
        check("rd_oe_n0", 32'(data_oe), 32'h0);
        idle(2);
        check("rd_oe_n2", 32'(data_oe), 32'h0);
        idle(1);
        check("rd_w0_oe", 32'(data_oe), 32'h1);
        check("rd_w0", 32'(data_out), 32'h3333);
        idle(1);
        check("rd_w1", 32'(data_out), 32'h4444);
        idle(1);
        check("rd_w2", 32'(data_out), 32'h1111);
        idle(1);
        check("rd_w3", 32'(data_out), 32'h2222);
        check("rd_w3_oe", 32'(data_oe), 32'h1);
        idle(1);
        check("rd_end_oe", 32'(data_oe), 32'h0);

        // DQM: 0xABCD with high byte inhibited over 0xFFFF
        data_in = 16'hFFFF;
        drive(C_WRITE, 2'd0, 12'h020);
        idle(3);
        data_in = 16'hABCD; data_mask = 2'b10;
        drive(C_WRITE, 2'd0, 12'h020);
        data_mask = 2'b11;
        idle(3);
        data_mask = 2'b00; data_in = 16'h0000;
        drive(C_READ, 2'd0, 12'h020);
        idle(3);
        check("dqm_w0", 32'(data_out), 32'hFFCD);
        idle(1);
        check("dqm_w1", 32'(data_out), 32'hFFFF);
        idle(3);

        // WRITE on the first read-data edge drops the read the same edge
        drive(C_READ, 2'd0, 12'h010);
        idle(2);
        data_mask = 2'b11;
        drive(C_WRITE, 2'd0, 12'h010);
        check("wr_cuts_rd_oe", 32'(data_oe), 32'h0);
        idle(3);
        data_mask = 2'b00;

        // READ at ACT+2 violates tRCD and produces no data
        drive(C_ACT, 2'd1, 12'h007);
        idle(1);
        drive(C_READ, 2'd1, 12'h000);
        check("trcd_err", 32'(err), 32'h08);
        idle(3);
        check("trcd_no_oe", 32'(data_oe), 32'h0);
        clear_err();
        check("err_clear", 32'(err), 32'h0);

        // AR with banks open
        drive(C_AR, 2'd0, 12'h000);
        check("ar_open_err", 32'(err), 32'h02);
        clear_err();

        // ACT one cycle after PRE violates tRP
        drive(C_PRE, 2'd0, 12'h400);
        drive(C_ACT, 2'd0, 12'h000);
        check("trp_err", 32'(err), 32'h10);
        clear_err();

        // ACT inside tRFC, then refresh interval boundary
        drive(C_AR, 2'd0, 12'h000);
        check("ar_ok", 32'(err), 32'h0);
        idle(1);
        drive(C_ACT, 2'd0, 12'h000);
        check("trfc_err", 32'(err), 32'h20);
        clear_err();
        check("trfc_cleared", 32'(err), 32'h0);
        idle(T_REFI - 4);
        check("refi_before", 32'(err), 32'h0);
        idle(1);
        check("refi_reached", 32'(err), 32'h40);

        // Reset in the middle of a read burst
        drive(C_AR, 2'd0, 12'h000);
        idle(6);
        drive(C_ACT, 2'd2, 12'h001);
        idle(2);
        drive(C_READ, 2'd2, 12'h000);
        idle(3);
        check("rst_burst_oe_before", 32'(data_oe), 32'h1);
        rst = 1'b1;
        idle(1);
        check("rst_burst_oe", 32'(data_oe), 32'h0);
        check("rst_burst_ready", 32'(ready), 32'h0);
        check("rst_burst_mode", 32'(mode), 32'h0);
        check("rst_burst_data", 32'(data_out), 32'h0);
        rst = 1'b0;
        drive(C_READ, 2'd0, 12'h000);
        check("pre_init_read_err", 32'(err), 32'h01);
        idle(4);
        check("pre_init_read_oe", 32'(data_oe), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable SDR SDRAM responder: the device-side end of the 16-bit SDRAM command bus driven by the wishbone SDRAM controller. It decodes cs_n/ras/cas/we commands, enforces and checks the power-up sequence, mode register and core timings, and serves read/write bursts from an internal block RAM. It is used as an in-fabric memory stand-in for loopback builds and as the golden responder in controller benches. Protocol violations are reported through sticky error flags.

## Interface
Parameters:
- COL_BITS, 8, column address width (address[COL_BITS-1:0])
- MEM_AW, 12, backing-store depth log2 in 16-bit words
- T_RCD, 3, ACT to READ/WRITE minimum, cycles
- T_RP, 3, PRE to ACT minimum, cycles
- T_RFC, 7, AR to next command minimum, cycles
- T_MRD, 2, MRS to next command minimum, cycles
- T_REFI, 1560, maximum cycles between AR commands once ready

Ports:
- clk  in  1  device clock (same edge the controller launches commands on)
- rst  in  1  synchronous, active-high
- cke  in  1  clock enable; low means every cycle is treated as NOP
- cs_n  in  1  chip select, active low; high means NOP
- ras, cas, we  in  1 each  command bits, active low
- address  in  12  row (ACT), column + A10 auto-precharge flag (READ/WRITE), A10 all-banks flag (PRE), mode (MRS)
- bank  in  2  bank select
- data_in  in  16  DQ sampled while the controller drives
- data_mask  in  2  DQM; bit high inhibits that byte on writes
- data_out  out  16  DQ read data
- data_oe  out  1  high while data_out must be driven
- ready  out  1  init sequence complete
- mode  out  12  current mode register
- err_clear  in  1  clears err
- err  out  8  sticky violation flags

## Operation
- Command {ras,cas,we}: 111 NOP, 011 ACT, 101 READ, 100 WRITE, 110 BST, 010 PRE, 001 AR, 000 MRS.
- Init FSM: WAIT_PRE -> WAIT_AR1 -> WAIT_AR2 -> WAIT_MRS -> READY. Each state advances only on PRE with A10=1, AR, AR, MRS respectively; any other non-NOP sets err[0] and the FSM stays in its state. ready=1 in READY only.
- Mode: [2:0] burst length 000=1, 001=2, 010=4, 011=8; [3] burst type (must be 0); [6:4] CAS latency (2 or 3); [9] 1 = single-word writes. Any other value sets err[7] and is retained as written, with BL=1 and CL=2 applied.
- Bank state, one per bank: open flag, open row, tRCD timer, tRP timer.
  - ACT on an open bank: err[1].
  - ACT before T_RP elapses: err[4].
  - READ/WRITE on a closed bank: err[2].
  - READ/WRITE before T_RCD elapses: err[3].
  - Erroring commands are otherwise ignored.
- PRE closes the addressed bank, or all banks if A10=1. A10=1 on READ/WRITE closes that bank after the burst ends.
- AR with any bank open: err[1]. Any non-NOP inside T_RFC after AR, or inside T_MRD after MRS: err[5].
- After ready, a refresh interval counter counts up and is cleared by AR. Reaching T_REFI sets err[6].
- Storage index = {bank, row[MEM_AW-COL_BITS-3:0], col}; upper row bits alias.
- Bursts:
  - Column advances sequentially and wraps within the BL-aligned block.
  - A new READ/WRITE, BST, or PRE to the bursting bank terminates the current burst immediately.
  - WRITE with mode[9]=1 writes one word.
- err bits are set on the offending cycle and hold until err_clear. When err_clear and a new violation occur in the same cycle, set wins.

## Timing
- Reset values: data_out 0, data_oe 0, ready 0, mode 0, err 0. The FSM returns to WAIT_PRE, all banks close, and all timers and burst state clear. A burst in progress at reset is abandoned with no further writes.
- READ at edge n: first word on data_out with data_oe=1 at edge n+CL, then one word per cycle for BL cycles. A read pipeline of depth 3 holds the command/column. The RAM read is registered (1 cycle), which fits within CL≥2.
- WRITE at edge n: data_in/data_mask sampled at edge n for the first word, then n+1 … n+BL-1.
- A READ issued while write data is still in flight cuts the write burst at that edge.
- A WRITE issued while read data is pending drops the remaining read words; data_oe falls the same edge.
- Timers load on the command edge. A command is legal when it arrives ≥T cycles later (T_RCD=3: ACT at n, READ at n+3 legal, at n+2 violation).

## Structure
- Command encodings, mode-field positions and default timings live in the shared sdram include with the SDRAM_CMD_* constants. The responder uses those constants.
- One sub-module, sdram_responder_bank: open flag, row, tRCD/tRP timers, violation outputs. Instantiated 4×.
- The top level holds the init FSM, mode register, burst/read pipeline, refresh counter, and an inferred simple dual-port RAM.

## Test plan
- Correct init (PRE A10=1, AR, AR, MRS 0x032) -> ready=1 after MRS, mode=0x032, err=0.
- ACT b0 row 5, WRITE col 0x10 data 0x1111..0x4444 at BL=4, then READ col 0x12 at CL=3 -> data_out 0x3333, 0x4444, 0x1111, 0x2222 beginning edge n+3.
- WRITE data 0xABCD with data_mask=2'b10 over 0xFFFF -> readback 0xFFCD.
- READ at ACT+2 -> err[3] set and no data_oe. err_clear -> err=0.
- AR issued with bank 1 open -> err[1]. No AR for T_REFI cycles after ready -> err[6].
- rst asserted mid read burst -> data_oe=0 next edge, ready=0, a subsequent READ before init sets err[0].
